// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller.
//   state_e     : controller state encoding (RUN, WAIT, DRAIN, HALTED)
//   ctl_t       : bundle of the seven pipeline-register controls
//   CTL_*       : control patterns for each pipeline action
//   DEF_*       : default timing parameters
// Used by pipe_hazard_ctrl (optional feature macro: PIPE_STAT_EN).
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_WAIT   = 2'b01,
        ST_DRAIN  = 2'b10,
        ST_HALTED = 2'b11
    } state_e;

    // Field order is also the bit order used when the struct is unpacked
    // onto the output ports.
    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic id_exe_we;
        logic exe_mem_we;
        logic mem_wb_we;
        logic if_id_flush;
        logic id_exe_flush;
    } ctl_t;

    localparam ctl_t CTL_OFF    = 7'b000_0000;  // freeze, halted or in reset
    localparam ctl_t CTL_BRANCH = 7'b111_1111;  // advance, squash IF/ID and ID/EXE
    localparam ctl_t CTL_STALL  = 7'b001_1101;  // hold front end, bubble into EXE
    localparam ctl_t CTL_NORMAL = 7'b111_1100;  // everything advances

    localparam int DEF_MEM_TIMEOUT  = 16;
    localparam int DEF_DRAIN_CYCLES = 3;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// sat_counter: saturating event counter with synchronous active-high reset.
//   clk   : rising-edge clock
//   rst   : synchronous reset, clears value
//   inc   : count one event this cycle
//   value : current count, sticks at all-ones
// Only compiled into the design when PIPE_STAT_EN is defined, since it has
// no other user.
`ifdef PIPE_STAT_EN
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] value
);

    logic [CNT_W-1:0] value_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
        end else if (inc) begin
            value_q <= sat_inc(value_q);
        end
    end

    assign value = value_q;

endmodule
`endif

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: sequencing controller for the 5-stage pipeline.
// Resolves load-use stalls, taken-branch flushes, data-memory wait freezes
// (with timeout to a sticky error) and the halt drain sequence.
//
// Ports
//   clk, rst                      : clock, synchronous active-high reset
//   LOAD_DEPEN                    : load-use hazard on the ID instruction
//   BRANCH_TAKEN                  : branch/jump in EXE resolved taken
//   MEM_BUSY                      : data memory not ready this cycle
//   HALT_REQ                      : halt decoded in ID
//   PC_WE .. MEM_WB_WE            : pipeline register write enables
//   IF_ID_FLUSH, ID_EXE_FLUSH     : load a bubble into the register
//   HALTED                        : core stopped (registered)
//   ERR                           : memory timeout, sticky until rst
//   STALL_CNT, FLUSH_CNT          : statistics, present with PIPE_STAT_EN
//
// Optional feature macro: PIPE_STAT_EN adds the saturating STALL_CNT and
// FLUSH_CNT counters and their ports.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT  = DEF_MEM_TIMEOUT,
    parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
    parameter int CNT_W        = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic LOAD_DEPEN,
    input  logic BRANCH_TAKEN,
    input  logic MEM_BUSY,
    input  logic HALT_REQ,
    output logic PC_WE,
    output logic IF_ID_WE,
    output logic ID_EXE_WE,
    output logic EXE_MEM_WE,
    output logic MEM_WB_WE,
    output logic IF_ID_FLUSH,
    output logic ID_EXE_FLUSH,
    output logic HALTED,
    output logic ERR
`ifdef PIPE_STAT_EN
    ,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [CNT_W-1:0] FLUSH_CNT
`endif
);

    localparam int WCNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam int DCNT_W = $clog2(DRAIN_CYCLES + 1);

    localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);
    localparam logic [DCNT_W-1:0] DCNT_ONE  = DCNT_W'(1);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DRAIN_CYCLES);

    // Elaboration-time parameter sanity checks.
    if (MEM_TIMEOUT < 2) begin : g_bad_timeout
        $error("pipe_hazard_ctrl: MEM_TIMEOUT must be >= 2");
    end
    if (DRAIN_CYCLES < 1) begin : g_bad_drain
        $error("pipe_hazard_ctrl: DRAIN_CYCLES must be >= 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt
        $error("pipe_hazard_ctrl: CNT_W must be >= 1");
    end

    state_e            state_q;
    logic [WCNT_W-1:0] wcnt_q;
    logic [DCNT_W-1:0] dcnt_q;
    logic              halted_q;
    logic              err_q;

    ctl_t ctl;
    logic halt_accept;

    // Control decode: purely combinational from state and inputs so the
    // pipeline sees stalls and flushes in the same cycle as the hazard.
    always_comb begin
        ctl         = CTL_OFF;
        halt_accept = 1'b0;
        if (rst) begin
            ctl = CTL_OFF;
        end else begin
            unique case (state_q)
                ST_RUN, ST_WAIT: begin
                    // A taken branch squashes the ID instruction, so any
                    // load-use or halt it carries is moot.
                    if (MEM_BUSY) begin
                        ctl = CTL_OFF;
                    end else if (BRANCH_TAKEN) begin
                        ctl = CTL_BRANCH;
                    end else if (LOAD_DEPEN) begin
                        ctl = CTL_STALL;
                    end else if (HALT_REQ) begin
                        ctl         = CTL_STALL;
                        halt_accept = 1'b1;
                    end else begin
                        ctl = CTL_NORMAL;
                    end
                end
                ST_DRAIN: begin
                    // Front end stays frozen; bubbles push the tail out.
                    ctl = MEM_BUSY ? CTL_OFF : CTL_STALL;
                end
                default: begin
                    ctl = CTL_OFF;
                end
            endcase
        end
    end

    assign {PC_WE, IF_ID_WE, ID_EXE_WE, EXE_MEM_WE, MEM_WB_WE,
            IF_ID_FLUSH, ID_EXE_FLUSH} = ctl;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            wcnt_q   <= '0;
            dcnt_q   <= '0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (MEM_BUSY) begin
                        state_q <= ST_WAIT;
                        wcnt_q  <= WCNT_ONE;
                    end else if (halt_accept) begin
                        state_q <= ST_DRAIN;
                        dcnt_q  <= DCNT_ONE;
                    end
                end
                ST_WAIT: begin
                    if (MEM_BUSY) begin
                        // wcnt counts busy cycles already completed, so the
                        // last value ends the MEM_TIMEOUT-th busy cycle.
                        if (wcnt_q == WCNT_LAST) begin
                            state_q  <= ST_HALTED;
                            halted_q <= 1'b1;
                            err_q    <= 1'b1;
                        end else begin
                            wcnt_q <= wcnt_q + WCNT_W'(1);
                        end
                    end else begin
                        wcnt_q <= '0;
                        if (halt_accept) begin
                            state_q <= ST_DRAIN;
                            dcnt_q  <= DCNT_ONE;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Frozen cycles hold dcnt; no timeout while draining.
                    if (!MEM_BUSY) begin
                        if (dcnt_q == DCNT_LAST) begin
                            state_q  <= ST_HALTED;
                            halted_q <= 1'b1;
                        end else begin
                            dcnt_q <= dcnt_q + DCNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= ST_HALTED;
                end
            endcase
        end
    end

    assign HALTED = halted_q;
    assign ERR    = err_q;

`ifdef PIPE_STAT_EN
    logic stall_inc;
    logic flush_inc;

    assign stall_inc = !rst && !ctl.pc_we && (state_q != ST_HALTED);
    assign flush_inc = ctl.if_id_flush;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .value (STALL_CNT)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .value (FLUSH_CNT)
    );
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed scenarios followed by random
// traffic, each cycle compared against a rule-level reference model.
module tb_pipe_hazard_ctrl;

    localparam int MEM_TIMEOUT  = 16;
    localparam int DRAIN_CYCLES = 3;
    localparam int CNT_W        = 32;

    logic clk          = 1'b0;
    logic rst          = 1'b1;
    logic LOAD_DEPEN   = 1'b0;
    logic BRANCH_TAKEN = 1'b0;
    logic MEM_BUSY     = 1'b0;
    logic HALT_REQ     = 1'b0;
    logic PC_WE, IF_ID_WE, ID_EXE_WE, EXE_MEM_WE, MEM_WB_WE;
    logic IF_ID_FLUSH, ID_EXE_FLUSH, HALTED, ERR;
`ifdef PIPE_STAT_EN
    logic [CNT_W-1:0] STALL_CNT, FLUSH_CNT;
`endif

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .DRAIN_CYCLES(DRAIN_CYCLES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .LOAD_DEPEN  (LOAD_DEPEN),
        .BRANCH_TAKEN(BRANCH_TAKEN),
        .MEM_BUSY    (MEM_BUSY),
        .HALT_REQ    (HALT_REQ),
        .PC_WE       (PC_WE),
        .IF_ID_WE    (IF_ID_WE),
        .ID_EXE_WE   (ID_EXE_WE),
        .EXE_MEM_WE  (EXE_MEM_WE),
        .MEM_WB_WE   (MEM_WB_WE),
        .IF_ID_FLUSH (IF_ID_FLUSH),
        .ID_EXE_FLUSH(ID_EXE_FLUSH),
        .HALTED      (HALTED),
        .ERR         (ERR)
`ifdef PIPE_STAT_EN
        ,
        .STALL_CNT   (STALL_CNT),
        .FLUSH_CNT   (FLUSH_CNT)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: counts of consecutive busy cycles and remaining
    // drain bubbles, plus halted/error flags.
    bit               m_halted     = 1'b0;
    bit               m_err        = 1'b0;
    bit               m_drain      = 1'b0;
    int               m_busy_run   = 0;
    int               m_drain_left = 0;
    logic [CNT_W-1:0] m_stall      = '0;
    logic [CNT_W-1:0] m_flush      = '0;

    // Expected {PC,IF_ID,ID_EXE,EXE_MEM,MEM_WB WE, IF_ID flush, ID_EXE flush}.
    function automatic logic [6:0] exp_ctl(input bit r, ld, br, mb, hr);
        if (r || m_halted) return 7'b0000000;
        if (m_drain)       return mb ? 7'b0000000 : 7'b0011101;
        if (mb)            return 7'b0000000;
        if (br)            return 7'b1111111;
        if (ld || hr)      return 7'b0011101;
        return 7'b1111100;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit r, ld, br, mb, hr, input logic [6:0] e);
        if (r) begin
            m_halted = 0; m_err = 0; m_drain = 0;
            m_busy_run = 0; m_drain_left = 0;
            m_stall = '0; m_flush = '0;
        end else begin
            if (!e[6] && !m_halted && m_stall != '1) m_stall++;
            if (e[1] && m_flush != '1) m_flush++;
            if (m_halted) begin
                // stays halted until reset
            end else if (m_drain) begin
                if (!mb) begin
                    m_drain_left--;
                    if (m_drain_left == 0) begin
                        m_drain  = 0;
                        m_halted = 1;
                    end
                end
            end else if (mb) begin
                m_busy_run++;
                if (m_busy_run == MEM_TIMEOUT) begin
                    m_halted = 1;
                    m_err    = 1;
                end
            end else begin
                m_busy_run = 0;
                if (hr && !br && !ld) begin
                    m_drain      = 1;
                    m_drain_left = DRAIN_CYCLES;
                end
            end
        end
    endtask

    task automatic cycle(input string tag, input bit r, ld, br, mb, hr);
        logic [6:0] e;
        @(negedge clk);
        rst = r; LOAD_DEPEN = ld; BRANCH_TAKEN = br; MEM_BUSY = mb; HALT_REQ = hr;
        #1;
        e = exp_ctl(r, ld, br, mb, hr);
        check($sformatf("%s/ctl", tag),
              {25'd0, PC_WE, IF_ID_WE, ID_EXE_WE, EXE_MEM_WE, MEM_WB_WE, IF_ID_FLUSH, ID_EXE_FLUSH},
              {25'd0, e});
        check($sformatf("%s/halted", tag), 32'(HALTED), 32'(m_halted));
        check($sformatf("%s/err", tag), 32'(ERR), 32'(m_err));
`ifdef PIPE_STAT_EN
        check($sformatf("%s/stall_cnt", tag), 32'(STALL_CNT), 32'(m_stall));
        check($sformatf("%s/flush_cnt", tag), 32'(FLUSH_CNT), 32'(m_flush));
`endif
        model_step(r, ld, br, mb, hr, e);
    endtask

    initial begin
        repeat (2) @(posedge clk);

        // Reset and idle
        cycle("reset", 1, 0, 0, 0, 0);
        cycle("idle", 0, 0, 0, 0, 0);

        // Single load-use stall
        cycle("ld_stall", 0, 1, 0, 0, 0);
        cycle("ld_after", 0, 0, 0, 0, 0);
        cycle("ld_after2", 0, 0, 0, 0, 0);

        // Branch together with load-use
        cycle("rst_b", 1, 0, 0, 0, 0);
        cycle("br_ld", 0, 1, 1, 0, 0);
        cycle("br_after", 0, 0, 0, 0, 0);

        // Memory freeze with a branch held in EXE
        for (int i = 0; i < 5; i++) cycle("frz_br", 0, 0, 1, 1, 0);
        cycle("frz_release", 0, 0, 1, 0, 0);
        cycle("frz_after", 0, 0, 0, 0, 0);

        // Memory timeout
        for (int i = 0; i < MEM_TIMEOUT; i++) cycle("tmo_busy", 0, 0, 0, 1, 0);
        cycle("tmo_halt", 0, 0, 0, 0, 0);
        cycle("tmo_halt2", 0, 1, 1, 0, 1);
        cycle("tmo_rst", 1, 0, 0, 0, 0);
        cycle("tmo_clear", 0, 0, 0, 0, 0);

        // Halt with one frozen drain cycle
        cycle("halt_acc", 0, 0, 0, 0, 1);
        cycle("drain1", 0, 1, 1, 0, 0);
        cycle("drain_frz", 0, 0, 0, 1, 0);
        cycle("drain2", 0, 0, 0, 0, 0);
        cycle("drain3", 0, 0, 0, 0, 0);
        cycle("halted", 0, 0, 0, 0, 0);
        cycle("halted2", 0, 0, 0, 1, 0);

        // Reset in the middle of a drain
        cycle("rst_c", 1, 0, 0, 0, 0);
        cycle("halt_acc2", 0, 0, 0, 0, 1);
        cycle("drain_mid", 0, 0, 0, 0, 0);
        cycle("rst_mid", 1, 0, 0, 0, 0);
        cycle("post_rst", 0, 0, 0, 0, 0);

        // Halt accepted on release from a memory wait
        cycle("wait_busy", 0, 0, 0, 1, 0);
        cycle("wait_halt", 0, 0, 0, 0, 1);
        cycle("wait_drain", 0, 0, 0, 0, 0);

        // Random traffic
        cycle("rnd_rst", 1, 0, 0, 0, 0);
        for (int i = 0; i < 800; i++) begin
            bit r, ld, br, mb, hr;
            r  = m_halted ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 99) == 0);
            ld = ($urandom_range(0, 3) == 0);
            br = ($urandom_range(0, 6) == 0);
            mb = (i % 200 >= 170 && i % 200 < 190) ? 1'b1 : ($urandom_range(0, 6) == 0);
            hr = ($urandom_range(0, 29) == 0);
            cycle("rnd", r, ld, br, mb, hr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
